// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator call scheduler.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2
    } state_t;

    // Widest floor field the helpers support; blocks slice down to their FLOOR_W.
    localparam int MAX_FLOOR_W = 8;
    localparam int MAX_FLOORS  = 2**MAX_FLOOR_W - 2;

    localparam logic [MAX_FLOOR_W-1:0] FLOOR_NONE = '1;

    // One-hot bit for a 1-based floor; all zeros when the floor is 0 or above n_floors.
    function automatic logic [MAX_FLOORS-1:0] onehot_of_floor(
        input logic [MAX_FLOOR_W-1:0] floor,
        input int                     n_floors
    );
        logic [MAX_FLOORS-1:0] mask;
        mask = '0;
        if (floor != '0 && int'(floor) <= n_floors)
            mask[floor - MAX_FLOOR_W'(1)] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/floor_priority_encoder.sv
// Combinational search of a floor request vector for its lowest or highest set bit.
module floor_priority_encoder
    import elevator_pkg::*;
#(
    parameter int N_FLOORS    = 5,
    parameter int FLOOR_W     = 4,
    parameter bit FIND_LOWEST = 1'b1
) (
    input  logic [N_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]  floor
);

    localparam logic [FLOOR_W-1:0] FLOOR_NONE_W = FLOOR_NONE[FLOOR_W-1:0];

    // The last match in scan order wins, so scan order decides lowest vs highest.
    always_comb begin
        floor = FLOOR_NONE_W;
        if (FIND_LOWEST) begin
            for (int i = N_FLOORS - 1; i >= 0; i--)
                if (req[i]) floor = FLOOR_W'(i + 1);
        end else begin
            for (int i = 0; i < N_FLOORS; i++)
                if (req[i]) floor = FLOOR_W'(i + 1);
        end
    end

endmodule

// File: rtl/floor_request_scheduler.sv
// SCAN-style elevator call scheduler: latches calls, tracks direction, publishes next target.
//   state     | meaning
//   IDLE      | no travel direction; serves a call at the current floor in place
//   MOVE_UP   | serving calls at or above the car, nearest first
//   MOVE_DOWN | serving calls at or below the car, nearest first
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int N_FLOORS    = 5,
    parameter int FLOOR_W     = 4,
    parameter bit UP_PRIORITY = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] req_set,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                arrive,
    output logic [N_FLOORS-1:0] req_pending,
    output logic [FLOOR_W-1:0]  target_floor,
    output logic                target_valid,
    output logic                dir_up,
    output logic                dir_down
);

    localparam logic [FLOOR_W-1:0] FLOOR_NONE_W = FLOOR_NONE[FLOOR_W-1:0];

    state_t               state, next_state;
    logic [N_FLOORS-1:0]  req_q, clr;
    logic [N_FLOORS-1:0]  ge_mask, le_mask;
    logic [FLOOR_W-1:0]   up_cand, dn_cand;
    logic [FLOOR_W-1:0]   next_target;
    logic                 next_valid;
    logic                 in_range, up_ok, dn_ok, at_floor;

    assign in_range = (cur_floor != '0) && (int'(cur_floor) <= N_FLOORS);

    // Clearing has priority over a simultaneous set: the caller is already being served.
    assign clr = arrive ? N_FLOORS'(onehot_of_floor(MAX_FLOOR_W'(cur_floor), N_FLOORS)) : '0;

    always_comb begin
        ge_mask = '0;
        le_mask = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            ge_mask[i] = in_range && (i + 1 >= int'(cur_floor));
            le_mask[i] = in_range && (i + 1 <= int'(cur_floor));
        end
    end

    floor_priority_encoder #(
        .N_FLOORS    (N_FLOORS),
        .FLOOR_W     (FLOOR_W),
        .FIND_LOWEST (1'b1)
    ) u_up_enc (
        .req   (req_q & ge_mask),
        .floor (up_cand)
    );

    floor_priority_encoder #(
        .N_FLOORS    (N_FLOORS),
        .FLOOR_W     (FLOOR_W),
        .FIND_LOWEST (1'b0)
    ) u_dn_enc (
        .req   (req_q & le_mask),
        .floor (dn_cand)
    );

    assign up_ok    = (up_cand != FLOOR_NONE_W);
    assign dn_ok    = (dn_cand != FLOOR_NONE_W);
    assign at_floor = up_ok && (up_cand == cur_floor);

    always_comb begin
        next_state  = state;
        next_target = FLOOR_NONE_W;
        next_valid  = 1'b0;
        if (in_range) begin
            unique case (state)
                IDLE: begin
                    if (at_floor) begin
                        next_target = cur_floor;
                        next_valid  = 1'b1;
                    end else if (up_ok && (UP_PRIORITY || !dn_ok)) begin
                        next_state  = MOVE_UP;
                        next_target = up_cand;
                        next_valid  = 1'b1;
                    end else if (dn_ok) begin
                        next_state  = MOVE_DOWN;
                        next_target = dn_cand;
                        next_valid  = 1'b1;
                    end
                end
                MOVE_UP: begin
                    if (up_ok) begin
                        next_target = up_cand;
                        next_valid  = 1'b1;
                    end else if (dn_ok) begin
                        next_state  = MOVE_DOWN;
                        next_target = dn_cand;
                        next_valid  = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
                MOVE_DOWN: begin
                    if (dn_ok) begin
                        next_target = dn_cand;
                        next_valid  = 1'b1;
                    end else if (up_ok) begin
                        next_state  = MOVE_UP;
                        next_target = up_cand;
                        next_valid  = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q        <= '0;
            state        <= IDLE;
            target_floor <= FLOOR_NONE_W;
            target_valid <= 1'b0;
            dir_up       <= 1'b0;
            dir_down     <= 1'b0;
        end else begin
            req_q        <= (req_q | req_set) & ~clr;
            state        <= next_state;
            target_floor <= next_target;
            target_valid <= next_valid;
            dir_up       <= (next_state == MOVE_UP);
            dir_down     <= (next_state == MOVE_DOWN);
        end
    end

    assign req_pending = req_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler with both UP_PRIORITY settings side by side.
module tb_floor_request_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] req_set;
    logic [3:0] cur_floor;
    logic       arrive;

    logic [4:0] pend_u, pend_d;
    logic [3:0] tgt_u, tgt_d;
    logic       val_u, val_d, up_u, up_d, dn_u, dn_d;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    floor_request_scheduler #(.N_FLOORS(5), .FLOOR_W(4), .UP_PRIORITY(1'b1)) dut_u (
        .clk(clk), .rst_n(rst_n), .req_set(req_set), .cur_floor(cur_floor), .arrive(arrive),
        .req_pending(pend_u), .target_floor(tgt_u), .target_valid(val_u),
        .dir_up(up_u), .dir_down(dn_u)
    );

    floor_request_scheduler #(.N_FLOORS(5), .FLOOR_W(4), .UP_PRIORITY(1'b0)) dut_d (
        .clk(clk), .rst_n(rst_n), .req_set(req_set), .cur_floor(cur_floor), .arrive(arrive),
        .req_pending(pend_d), .target_floor(tgt_d), .target_valid(val_d),
        .dir_up(up_d), .dir_down(dn_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; req_set = '0; cur_floor = 4'd1; arrive = 1'b0;

        // reset asserted mid-clock
        #12 rst_n = 1'b0;
        #1;
        check("rst_pend", pend_u, 5'b00000);
        check("rst_tgt",  tgt_u,  4'hF);
        check("rst_val",  val_u,  1'b0);
        check("rst_dir",  {up_u, dn_u}, 2'b00);
        check("rst_tgt_d", tgt_d, 4'hF);
        #20;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("post_rst_pend", pend_u, 5'b00000);
        check("post_rst_tgt",  tgt_u,  4'hF);
        check("post_rst_dir",  {up_u, dn_u, val_u}, 3'b000);

        // single call above the car
        cur_floor = 4'd1; req_set = 5'b10000;
        tick(); req_set = '0;
        check("t2_pend", pend_u, 5'b10000);
        check("t2_val_early", val_u, 1'b0);
        tick();
        check("t2_tgt", tgt_u, 4'd5);
        check("t2_val", val_u, 1'b1);
        check("t2_up",  up_u,  1'b1);

        // preemption by a nearer call ahead
        cur_floor = 4'd2;
        tick();
        check("t3_tgt5", tgt_u, 4'd5);
        req_set = 5'b00100;
        tick(); req_set = '0;
        check("t3_pend", pend_u, 5'b10100);
        tick();
        check("t3_preempt", tgt_u, 4'd3);
        cur_floor = 4'd3; arrive = 1'b1;
        tick(); arrive = 1'b0;
        check("t3_clear", pend_u, 5'b10000);
        check("t3_tgt_hold", tgt_u, 4'd3);
        tick();
        check("t3_tgt_next", tgt_u, 4'd5);
        check("t3_up", up_u, 1'b1);

        // call behind is held, then reversal
        req_set = 5'b00001;
        tick(); req_set = '0;
        tick();
        check("t4_held_tgt", tgt_u, 4'd5);
        check("t4_held_pend", pend_u, 5'b10001);
        check("t4_held_dir", {up_u, dn_u}, 2'b10);
        cur_floor = 4'd4;
        tick();
        cur_floor = 4'd5; arrive = 1'b1;
        tick(); arrive = 1'b0;
        check("t4_pend", pend_u, 5'b00001);
        tick();
        check("t4_rev_dir", {up_u, dn_u}, 2'b01);
        check("t4_rev_tgt", tgt_u, 4'd1);
        cur_floor = 4'd3;
        tick();
        check("t4_down_tgt", tgt_u, 4'd1);
        cur_floor = 4'd1; arrive = 1'b1;
        tick(); arrive = 1'b0;
        check("t4_pend_empty", pend_u, 5'b00000);
        tick();
        check("t4_idle_dir", {up_u, dn_u}, 2'b00);
        check("t4_idle_tgt", tgt_u, 4'hF);
        check("t4_idle_val", val_u, 1'b0);

        // set and clear on the same floor: clear wins
        cur_floor = 4'd2; req_set = 5'b00010; arrive = 1'b1;
        tick(); req_set = '0; arrive = 1'b0;
        check("t5_conflict", pend_u, 5'b00000);
        tick();
        check("t5_conflict_val", val_u, 1'b0);
        req_set = 5'b00100;
        tick(); req_set = '0;
        tick();
        check("t5_tgt3", tgt_u, 4'd3);
        // out-of-range arrive is ignored and direction holds
        cur_floor = 4'd0; arrive = 1'b1;
        tick(); arrive = 1'b0;
        check("t5_floor0_pend", pend_u, 5'b00100);
        tick();
        check("t5_floor0_dir", up_u, 1'b1);
        cur_floor = 4'd6; arrive = 1'b1;
        tick(); arrive = 1'b0;
        check("t5_floor6_pend", pend_u, 5'b00100);
        cur_floor = 4'd3; arrive = 1'b1;
        tick(); arrive = 1'b0;
        check("t5_clear3", pend_u, 5'b00000);
        tick(); tick();
        check("t5_idle", {up_u, dn_u, val_u}, 3'b000);

        // IDLE tie between above and below
        cur_floor = 4'd3; req_set = 5'b10001;
        tick(); req_set = '0;
        check("t6_pend", pend_u, 5'b10001);
        tick();
        check("t6_up_dir", {up_u, dn_u}, 2'b10);
        check("t6_up_tgt", tgt_u, 4'd5);
        check("t6_dn_dir", {up_d, dn_d}, 2'b01);
        check("t6_dn_tgt", tgt_d, 4'd1);

        // reset mid-travel drops everything
        #3 rst_n = 1'b0;
        #1;
        check("t7_rst_pend", pend_u, 5'b00000);
        check("t7_rst_pend_d", pend_d, 5'b00000);
        check("t7_rst_out", {tgt_u, val_u, up_u, dn_u}, {4'hF, 3'b000});
        check("t7_rst_out_d", {tgt_d, val_d, up_d, dn_d}, {4'hF, 3'b000});
        tick();
        rst_n = 1'b1;
        tick();

        // call at the current floor served in place
        cur_floor = 4'd3; req_set = 5'b00100;
        tick(); req_set = '0;
        tick();
        check("t8_tgt", tgt_u, 4'd3);
        check("t8_val", val_u, 1'b1);
        check("t8_dir", {up_u, dn_u}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
